// File: rtl/i4004_clock_sequencer_if.sv
// Signal bundle between the i4004 clock sequencer and the CPU/peripheral side.
// Handshake: no valid/ready pairs; the levels are sampled every clk_i edge, step_i is a one-cycle pulse, and every output changes only on clk_i.
interface i4004_clock_sequencer_if;
  logic       sync_i;
  logic       halt_i;
  logic       step_i;
  logic       PHI1_o;
  logic       PHI2_o;
  logic       RESET_o;
  logic [2:0] phase_o;
  logic       cycle_stb_o;
  logic       locked_o;
  logic       sync_err_o;
  logic       halted_o;
  logic [1:0] dbg_state_o;

  modport master (
    input  sync_i, halt_i, step_i,
    output PHI1_o, PHI2_o, RESET_o, phase_o, cycle_stb_o,
    output locked_o, sync_err_o, halted_o, dbg_state_o
  );

  modport slave (
    output sync_i, halt_i, step_i,
    input  PHI1_o, PHI2_o, RESET_o, phase_o, cycle_stb_o,
    input  locked_o, sync_err_o, halted_o, dbg_state_o
  );
endinterface

// File: rtl/i4004_clock_sequencer.sv
// Two-phase PHI1/PHI2 generator, CPU reset stretcher, instruction-phase tracker
// and run/halt/single-step controller for the i4004 core.
module i4004_clock_sequencer #(
  parameter int unsigned DIV        = 4,
  parameter int unsigned RESET_HOLD = 8
) (
  input logic                     clk_i,
  input logic                     rst_i,
  i4004_clock_sequencer_if.master bus
);

  localparam int unsigned       HOLD_W    = 11;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD * 8);
  localparam logic [7:0]        DIV_MAX   = 8'(DIV - 1);
  localparam logic [2:0]        X3        = 3'd7;
  localparam logic [2:0]        A1        = 3'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STOPPING = 2'd1,
    HALTED   = 2'd2,
    STEP     = 2'd3
  } run_state_e;

  run_state_e        state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [1:0]        slot_q, slot_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        step_q, step_d;
  logic [2:0]        phase_q, phase_d;
  logic [1:0]        clean_q, clean_d;
  logic              locked_q, locked_d;
  logic              err_d;
  logic              phi1_q, phi2_q, reset_q, stb_q, err_q, halted_q;
  logic              advance, div_wrap, enter_slot2, period_end, halt_req;

  // Slot engine, reset hold counter and phase tracker.
  always_comb begin
    advance     = (state_q != HALTED);
    div_wrap    = advance && (div_q == DIV_MAX);
    enter_slot2 = div_wrap && (slot_q == 2'd1);
    period_end  = div_wrap && (slot_q == 2'd3);
    halt_req    = bus.halt_i && !reset_q;

    div_d  = div_q;
    slot_d = slot_q;
    if (advance) begin
      if (div_wrap) begin
        div_d  = '0;
        slot_d = slot_q + 2'd1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end

    hold_d = hold_q;
    if (period_end && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_W'(1);
    end

    phase_d  = phase_q;
    clean_d  = clean_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    if (enter_slot2) begin
      if (phase_q == X3) begin
        phase_d = A1;
        if (bus.sync_i) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          clean_d  = 2'd0;
        end else begin
          clean_d = (clean_q == 2'd2) ? 2'd2 : clean_q + 2'd1;
          if (clean_q != 2'd0) begin
            locked_d = 1'b1;
          end
        end
      end else if (!bus.sync_i) begin
        // SYNC arrived early: snap to A1 and start relocking.
        phase_d  = A1;
        err_d    = 1'b1;
        locked_d = 1'b0;
        clean_d  = 2'd0;
      end else begin
        phase_d = phase_q + 3'd1;
      end
    end
  end

  // Run control; clocks only stop or resume at slot 0, count 0.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      RUN: begin
        if (halt_req) state_d = STOPPING;
      end
      STOPPING: begin
        if (!bus.halt_i) begin
          state_d = RUN;
        end else if (period_end && (phase_q == X3)) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (!bus.halt_i) begin
          state_d = RUN;
        end else if (bus.step_i) begin
          state_d = STEP;
          step_d  = 4'd8;
        end
      end
      STEP: begin
        if (period_end) begin
          step_d = step_q - 4'd1;
          if (step_q == 4'd1) begin
            state_d = bus.halt_i ? HALTED : RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      div_q    <= '0;
      slot_q   <= '0;
      hold_q   <= HOLD_LOAD;
      step_q   <= '0;
      phase_q  <= X3;
      clean_q  <= '0;
      locked_q <= 1'b0;
      phi1_q   <= 1'b0;
      phi2_q   <= 1'b0;
      reset_q  <= 1'b1;
      stb_q    <= 1'b0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      slot_q   <= slot_d;
      hold_q   <= hold_d;
      step_q   <= step_d;
      phase_q  <= phase_d;
      clean_q  <= clean_d;
      locked_q <= locked_d;
      phi1_q   <= (state_d != HALTED) && (slot_d == 2'd0);
      phi2_q   <= (state_d != HALTED) && (slot_d == 2'd2);
      reset_q  <= (hold_d != '0);
      stb_q    <= enter_slot2;
      err_q    <= err_d;
      halted_q <= (state_d == HALTED);
    end
  end

  assign bus.PHI1_o      = phi1_q;
  assign bus.PHI2_o      = phi2_q;
  assign bus.RESET_o     = reset_q;
  assign bus.phase_o     = phase_q;
  assign bus.cycle_stb_o = stb_q;
  assign bus.locked_o    = locked_q;
  assign bus.sync_err_o  = err_q;
  assign bus.halted_o    = halted_q;
  assign bus.dbg_state_o = state_q;

endmodule
